// File: rtl/uart_prog_loader.sv
// Boot loader: pulls a length header and little-endian words from the UART RX FIFO and writes them to instruction memory.
// Optional LOADER_CSUM_EN: a trailing checksum word must equal the mod-2^32 sum of the data words.
module uart_prog_loader #(
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 0,
  parameter int MAX_WORDS   = 4096,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef LOADER_CSUM_EN
  localparam state_t FINAL_ST = S_CSUM;
  logic [31:0] csum_q;
`else
  localparam state_t FINAL_ST = S_DONE;
`endif

  state_t          state_q, state_d;
  logic            prog_q, start, load_start;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_q;
  logic [15:0]     word_idx, len_q;
  logic [CNT_W-1:0] idle_cnt;
  logic            intake, consume, word_done, timeout;
  logic [31:0]     full_word;

  assign start = prog & ~prog_q;
  assign intake = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef LOADER_CSUM_EN
                  || (state_q == S_CSUM)
`endif
                  ;
  assign consume    = intake & rx_valid;
  assign rx_rd      = consume;
  assign word_done  = consume && (byte_idx == 2'd3);
  assign timeout    = intake && !rx_valid && (idle_cnt == CNT_LAST);
  // The 4th byte is taken straight from the FIFO head, so only 3 bytes need buffering.
  assign full_word  = {rx_data, asm_q};
  assign word_count = word_idx;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    core_hold  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERR);
        core_hold = (state_q == S_ERR);
        if (start) begin
          state_d    = S_LEN;
          load_start = 1'b1;
        end
      end
      S_LEN: begin
        busy      = 1'b1;
        core_hold = 1'b1;
        if (word_done) begin
          if (full_word == 32'd0)                   state_d = FINAL_ST;
          else if (full_word > 32'(MAX_WORDS))      state_d = S_ERR;
          else                                      state_d = S_DATA;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        busy      = 1'b1;
        core_hold = 1'b1;
        if (word_done)    state_d = S_WRITE;
        else if (timeout) state_d = S_ERR;
      end
      S_WRITE: begin
        busy      = 1'b1;
        core_hold = 1'b1;
        mem_we    = 1'b1;
        if (mem_ack) state_d = ((word_idx + 16'd1) == len_q) ? FINAL_ST : S_DATA;
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        busy      = 1'b1;
        core_hold = 1'b1;
        if (word_done)    state_d = (full_word == csum_q) ? S_DONE : S_ERR;
        else if (timeout) state_d = S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Byte assembly, address/data capture, write bookkeeping and idle timer.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      prog_q    <= 1'b0;
      byte_idx  <= 2'd0;
      asm_q     <= 24'd0;
      word_idx  <= 16'd0;
      len_q     <= 16'd0;
      idle_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
`ifdef LOADER_CSUM_EN
      csum_q    <= 32'd0;
`endif
    end else begin
      prog_q <= prog;
      if (load_start) begin
        byte_idx <= 2'd0;
        word_idx <= 16'd0;
`ifdef LOADER_CSUM_EN
        csum_q   <= 32'd0;
`endif
      end else if (consume) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (consume) begin
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= rx_data;
          2'd1:    asm_q[15:8]  <= rx_data;
          2'd2:    asm_q[23:16] <= rx_data;
          default: ;
        endcase
      end
      // Timer runs only while waiting for FIFO bytes; being outside intake states clears it.
      if (!intake || consume) idle_cnt <= '0;
      else                    idle_cnt <= idle_cnt + CNT_W'(1);
      if (state_q == S_LEN && word_done) len_q <= full_word[15:0];
      if (state_q == S_DATA && word_done) begin
        mem_wdata <= full_word;
        mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx, 2'b00});
      end
      if (state_q == S_WRITE && mem_ack) begin
        word_idx <= word_idx + 16'd1;
`ifdef LOADER_CSUM_EN
        csum_q   <= csum_q + mem_wdata;
`endif
      end
    end
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader for the RISC-V + UART top level.
- Drains bytes from the UART receive FIFO, assembles them into little-endian 32-bit words, and writes them sequentially into instruction memory through a req/ack write port.
- Holds the core in reset (core_hold) while loading and releases it on successful completion.
- Sits between the UART RX FIFO and the instruction-memory write port; started by the `prog` input.

Parameters:
- ADDR_W, 16, width of mem_addr (byte address).
- BASE_ADDR, 0, byte address of the first word written.
- MAX_WORDS, 4096, largest accepted length header; larger values go to error.
- TIMEOUT_CYC, 1000000, maximum idle cycles between consumed bytes before error; counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock.
- Rst  in  1  asynchronous, active-high reset.
- prog  in  1  load request; a rising edge starts a load.
- rx_valid  in  1  RX FIFO non-empty.
- rx_data  in  8  RX FIFO head byte.
- rx_rd  out  1  FIFO pop; the byte on rx_data is consumed in the same cycle.
- mem_we  out  1  instruction-memory write request.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  32  write data.
- mem_ack  in  1  write accepted this cycle.
- core_hold  out  1  holds the core in reset.
- busy  out  1  load in progress.
- done  out  1  sticky: last load succeeded.
- err  out  1  sticky: last load failed.
- word_count  out  16  words written in the current/last load.

Behaviour:
- Reset (async, Rst=1):
  - State goes to IDLE.
  - All outputs are 0; mem_we drops immediately.
  - All internal counters, the checksum accumulator and the prog edge register clear.
- States: IDLE, LEN, DATA, WRITE, CSUM (macro only), DONE, ERR.
- Start:
  - prog is registered into prog_q; start = prog & ~prog_q.
  - Start is honoured only in IDLE, DONE or ERR. It moves to LEN; sets core_hold=1, busy=1; clears done, err, byte index, word index and checksum.
  - Start edges in any other state are ignored. Deasserting prog mid-load has no effect.
- Byte intake:
  - rx_rd = rx_valid && state in {LEN, DATA, CSUM}, combinational. At most one byte per cycle.
  - Byte k (k = 0..3) lands in bits [8k+7:8k] of the assembly register.
  - The 4th byte completes a word; the byte index wraps to 0.
- LEN, on word completion with length L:
  - L == 0: go to DONE (or CSUM when the macro is enabled).
  - L > MAX_WORDS: go to ERR.
  - Otherwise: latch L and go to DATA.
- DATA: on word completion go to WRITE. The completed word drives mem_wdata; mem_addr = BASE_ADDR + 4*word_index, truncated to ADDR_W.
- WRITE:
  - mem_we=1 with mem_addr and mem_wdata held stable until mem_ack; rx_rd=0 throughout.
  - The cycle mem_ack=1: mem_we falls next cycle, checksum += word (mod 2^32), word_index increments.
  - If the new index == L, go to DONE (or CSUM); otherwise return to DATA.
  - An ack in the first cycle of mem_we is legal: 1-cycle write.
- Timeout:
  - The idle counter clears on every consumed byte and on entry to LEN, DATA or CSUM. It does not count in WRITE.
  - Reaching TIMEOUT_CYC in LEN, DATA or CSUM goes to ERR.
- DONE: core_hold=0, busy=0, done=1. Stays until the next start.
- ERR: core_hold stays 1, busy=0, err=1. Stays until the next start or Rst.
- word_count = word_index; holds its value in DONE and ERR.
- FIFO bytes arriving in IDLE, DONE or ERR are not popped.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- Defined:
  - After the last data write, the loader enters CSUM and consumes one more 4-byte little-endian word.
  - Word equal to the running checksum (sum of all data words mod 2^32): go to DONE.
  - Otherwise: go to ERR.
  - For L == 0 the expected checksum is 0.
- Undefined: the CSUM state and accumulator are absent; the loader goes straight to DONE after the final write.

Test Plan:
- Normal 2-word load:
  - Stimulus: prog edge, then bytes 02 00 00 00 EF BE AD DE 78 56 34 12, mem_ack tied 1.
  - Expect: writes 0xDEADBEEF @0x0000 and 0x12345678 @0x0004; then done=1, core_hold=0, word_count=2.
- Delayed ack:
  - Stimulus: same load with mem_ack returned 3 cycles after mem_we rises.
  - Expect: mem_we high 4 cycles, address/data stable, rx_rd=0 while waiting even with rx_valid=1.
- Zero length:
  - Stimulus: header 00 00 00 00.
  - Expect: no mem_we; done=1 one cycle after the 4th byte (macro off).
- Oversize header:
  - Stimulus: MAX_WORDS=4, header 05 00 00 00.
  - Expect: err=1, core_hold=1, no writes; a new prog edge then a valid load gives done=1, err=0.
- Timeout and reset:
  - Stimulus: TIMEOUT_CYC=16, send 2 header bytes then stall.
  - Expect: err=1 exactly 16 cycles after the last byte.
  - Separately, assert Rst mid-WRITE: mem_we=0 immediately, all outputs 0.
- Checksum (LOADER_CSUM_EN):
  - Stimulus: the test 1 data followed by 67 15 E2 F0.
  - Expect: done=1.
  - Stimulus: the same load followed by 00 00 00 00.
  - Expect: err=1, core_hold=1.
